onchip_memory_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one single-port on-chip RAM (1024 x 32, byte-enabled, one-cycle read latency) between two Avalon-MM style masters. It sits between the two masters and the RAM's s1 port. It issues at most one access per cycle, stalls the loser with waitrequest, and returns read data with readdatavalid tagged to the issuing master.

---
 rtl/onchip_mem_pkg.sv | 28 ++
 rtl/onchip_memory_arbiter_rr_grant2.sv | 27 ++
 rtl/onchip_memory_arbiter.sv | 101 ++++++++++
 tb/tb_onchip_memory_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_pkg.sv
// Shared types for the two-master on-chip RAM arbiter.
// Holds the default geometry, the 1-bit master index type and the request-kind
// encoding with a helper that classifies a master's read/write strobes.
package onchip_mem_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    // Identifies one of the two masters (0 or 1).
    typedef logic mst_idx_t;

    typedef enum logic [1:0] {
        REQ_IDLE  = 2'd0,
        REQ_READ  = 2'd1,
        REQ_WRITE = 2'd2
    } req_kind_t;

    // Write dominates: read+write together is a plain write with no read return.
    function automatic req_kind_t req_kind(input logic rd, input logic wr);
        if (wr)
            return REQ_WRITE;
        else if (rd)
            return REQ_READ;
        else
            return REQ_IDLE;
    endfunction

endpackage

// File: rtl/onchip_memory_arbiter_rr_grant2.sv
// Two-way round-robin grant, purely combinational.
// Ports: req[1:0] active requests, rr = master favoured on contention,
//        gnt[1:0] one-hot grant (zero when idle), gnt_idx = winning master (0 when idle).
module rr_grant2
    import onchip_mem_pkg::*;
(
    input  logic [1:0] req,
    input  mst_idx_t   rr,
    output logic [1:0] gnt,
    output mst_idx_t   gnt_idx
);

    always_comb begin
        gnt_idx = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = rr;
            default: gnt_idx = 1'b0;
        endcase

        gnt = 2'b00;
        if (req != 2'b00)
            gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Round-robin arbiter sharing one single-port 1-cycle-latency RAM between two Avalon-MM masters.
// Ports: clk/reset; per master mN_* Avalon slave side (address, byteenable, read, write,
//        writedata, waitrequest, readdata, readdatavalid); mem_* RAM s1 side plus mem_clken.
module onchip_memory_arbiter
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              mem_clken
);

    req_kind_t  kind0;
    req_kind_t  kind1;
    req_kind_t  win_kind;
    logic [1:0] req;
    logic [1:0] gnt;
    mst_idx_t   gnt_idx;
    logic       granted;

    mst_idx_t   rr_q;
    logic       rd_pend_q;
    mst_idx_t   rd_own_q;

    assign kind0 = req_kind(m0_read, m0_write);
    assign kind1 = req_kind(m1_read, m1_write);

    // Requests are masked during reset so nothing reaches the RAM and both masters stall.
    assign req[0] = (kind0 != REQ_IDLE) && !reset;
    assign req[1] = (kind1 != REQ_IDLE) && !reset;

    rr_grant2 u_rr_grant2 (
        .req     (req),
        .rr      (rr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign granted  = |gnt;
    assign win_kind = gnt_idx ? kind1 : kind0;

    assign m0_waitrequest = !gnt[0];
    assign m1_waitrequest = !gnt[1];

    // gnt_idx is 0 when idle, so the data path defaults to master 0's fields.
    assign mem_address    = gnt_idx ? m1_address    : m0_address;
    assign mem_byteenable = gnt_idx ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = gnt_idx ? m1_writedata  : m0_writedata;
    assign mem_chipselect = granted;
    assign mem_write      = granted && (win_kind == REQ_WRITE);
    assign mem_clken      = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q      <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_own_q  <= 1'b0;
        end else begin
            // Favour the loser next time; hold the pointer across idle cycles.
            if (granted)
                rr_q <= !gnt_idx;
            rd_pend_q <= granted && (win_kind == REQ_READ);
            rd_own_q  <= gnt_idx;
        end
    end

    // RAM read data is broadcast; only the owner's valid strobe qualifies it.
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_pend_q && (rd_own_q == 1'b0);
    assign m1_readdatavalid = rd_pend_q && (rd_own_q == 1'b1);

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
module tb_onchip_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic [9:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;

    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    onchip_memory_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_readdata     (mem_readdata),
        .mem_clken        (mem_clken)
    );

    // Behavioural single-port RAM: registered read of the old word, byte-enabled write.
    logic [31:0] ram [1024];

    initial begin
        for (int i = 0; i < 1024; i++)
            ram[i] = 32'hA000_0000 | 32'(i);
    end

    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            mem_readdata <= ram[mem_address];
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b])
                        ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_masters();
        m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] a0, a1, pd;
    int          w, pw;
    bit          pv;

    initial begin
        idle_masters();
        reset = 1'b1;

        // ---- reset held 3 cycles with both masters requesting ----
        m0_read = 1'b1; m0_address = 10'd10;
        m1_read = 1'b1; m1_address = 10'd20;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_wait0", 32'(m0_waitrequest), 32'd1);
            chk("rst_wait1", 32'(m1_waitrequest), 32'd1);
            chk("rst_cs",    32'(mem_chipselect), 32'd0);
            chk("rst_wr",    32'(mem_write),      32'd0);
            chk("rst_rdv",   32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
            chk("rst_clken", 32'(mem_clken),      32'd1);
        end
        next_cycle();
        reset = 1'b0;

        // ---- continuous contention: M0,M1,M0,... with results one cycle later ----
        a0 = 32'd10; a1 = 32'd20; pv = 1'b0; pw = 0; pd = '0;
        for (int c = 0; c < 8; c++) begin
            m0_address = a0[9:0];
            m1_address = a1[9:0];
            @(negedge clk);
            w = c % 2;
            chk("cont_wait0", 32'(m0_waitrequest), (w != 0) ? 32'd1 : 32'd0);
            chk("cont_wait1", 32'(m1_waitrequest), (w != 1) ? 32'd1 : 32'd0);
            chk("cont_addr",  32'(mem_address), (w == 1) ? a1 : a0);
            chk("cont_cs",    32'(mem_chipselect), 32'd1);
            chk("cont_rdv0",  32'(m0_readdatavalid), (pv && pw == 0) ? 32'd1 : 32'd0);
            chk("cont_rdv1",  32'(m1_readdatavalid), (pv && pw == 1) ? 32'd1 : 32'd0);
            if (pv)
                chk("cont_data", (pw == 0) ? m0_readdata : m1_readdata, pd);
            pv = 1'b1;
            pw = w;
            pd = 32'hA000_0000 | ((w == 1) ? a1 : a0);
            next_cycle();
            if (w == 0) a0 = a0 + 1; else a1 = a1 + 1;
        end
        idle_masters();
        @(negedge clk);
        chk("cont_last_rdv1", 32'(m1_readdatavalid), 32'd1);
        chk("cont_last_rdv0", 32'(m0_readdatavalid), 32'd0);
        chk("cont_last_data", m1_readdata, 32'hA000_0017);
        chk("idle_cs",        32'(mem_chipselect), 32'd0);
        chk("idle_wait",      32'({m1_waitrequest, m0_waitrequest}), 32'd3);

        // ---- single master write then read ----
        next_cycle();
        m0_write = 1'b1; m0_address = 10'd5; m0_writedata = 32'hDEAD_BEEF; m0_byteenable = 4'hF;
        @(negedge clk);
        chk("sw_wait0", 32'(m0_waitrequest), 32'd0);
        chk("sw_memwr", 32'(mem_write), 32'd1);
        chk("sw_wdata", mem_writedata, 32'hDEAD_BEEF);
        next_cycle();
        m0_write = 1'b0; m0_read = 1'b1;
        @(negedge clk);
        chk("sr_wait0", 32'(m0_waitrequest), 32'd0);
        chk("sr_memwr", 32'(mem_write), 32'd0);
        chk("sr_rdv0_early", 32'(m0_readdatavalid), 32'd0);
        next_cycle();
        idle_masters();
        @(negedge clk);
        chk("sr_rdv0", 32'(m0_readdatavalid), 32'd1);
        chk("sr_rdv1", 32'(m1_readdatavalid), 32'd0);
        chk("sr_data", m0_readdata, 32'hDEAD_BEEF);

        // ---- byte lanes at the top address ----
        next_cycle();
        m1_write = 1'b1; m1_address = 10'd1023; m1_writedata = 32'h1122_3344;
        @(negedge clk);
        chk("be_wait1", 32'(m1_waitrequest), 32'd0);
        chk("be_addr",  32'(mem_address), 32'd1023);
        next_cycle();
        idle_masters();
        m0_write = 1'b1; m0_address = 10'd1023; m0_writedata = 32'h0000_00AA; m0_byteenable = 4'h1;
        @(negedge clk);
        chk("be_be", 32'(mem_byteenable), 32'h1);
        next_cycle();
        idle_masters();
        m0_read = 1'b1; m0_address = 10'd1023;
        next_cycle();
        idle_masters();
        @(negedge clk);
        chk("be_rdv0", 32'(m0_readdatavalid), 32'd1);
        chk("be_data", m0_readdata, 32'h1122_33AA);

        // ---- read+write together is a write with no read return ----
        next_cycle();
        m0_read = 1'b1; m0_write = 1'b1; m0_address = 10'd7; m0_writedata = 32'h5;
        @(negedge clk);
        chk("rw_memwr", 32'(mem_write), 32'd1);
        chk("rw_cs",    32'(mem_chipselect), 32'd1);
        next_cycle();
        idle_masters();
        @(negedge clk);
        chk("rw_no_rdv0", 32'(m0_readdatavalid), 32'd0);
        next_cycle();
        m0_read = 1'b1; m0_address = 10'd7;
        next_cycle();
        idle_masters();
        @(negedge clk);
        chk("rw_rdv0", 32'(m0_readdatavalid), 32'd1);
        chk("rw_data", m0_readdata, 32'h5);

        // ---- reset the cycle after an M1 read is accepted ----
        next_cycle();
        m1_read = 1'b1; m1_address = 10'd20;
        @(negedge clk);
        chk("mr1_wait1", 32'(m1_waitrequest), 32'd0);
        next_cycle();
        idle_masters();
        reset = 1'b1;
        @(negedge clk);
        chk("mr1_rdv1", 32'(m1_readdatavalid), 32'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("mr1_rdv1_after", 32'(m1_readdatavalid), 32'd0);

        // ---- M0 read leaves pointer at M1; reset must return it to M0 ----
        next_cycle();
        m0_read = 1'b1; m0_address = 10'd10;
        next_cycle();
        idle_masters();
        reset = 1'b1;
        @(negedge clk);
        chk("mr0_rdv0", 32'(m0_readdatavalid), 32'd0);
        next_cycle();
        reset = 1'b0;
        m0_read = 1'b1; m0_address = 10'd11;
        m1_read = 1'b1; m1_address = 10'd21;
        @(negedge clk);
        chk("post_rst_wait0", 32'(m0_waitrequest), 32'd0);
        chk("post_rst_wait1", 32'(m1_waitrequest), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("post_rst_rdv0", 32'(m0_readdatavalid), 32'd1);
        chk("post_rst_data", m0_readdata, 32'hA000_000B);
        chk("post_rst_m1win", 32'(m1_waitrequest), 32'd0);
        next_cycle();
        idle_masters();
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
